uart_rx_8n1: RTL and testbench
==============================

// Module: uart_rx_8n1
// PURPOSE
//  Receives 8N1 serial frames on the board UART_RXD pin and presents each byte
//  on a one-entry valid/ready holding register for user logic in the top level.
//  It sits between the UART_RXD pad and any consumer (command parser, FIFO, CPU bus).
//  It uses 16x oversampling with 3-sample majority voting, and reports framing and overrun errors.
// PARAMETERS
//  CLK_HZ      50000000  frequency of CLOCK_50 in Hz
//  BAUD        115200    line rate in bit/s
//  OS          16        oversample ticks per bit; even, >= 8
// PORTS
//  CLOCK_50      in   1  system clock; all logic is on its rising edge
//  RESET         in   1  synchronous, active-high reset
//  UART_RXD      in   1  asynchronous serial input; idles high
//  RX_DATA       out  8  received byte; valid while RX_VALID=1
//  RX_VALID      out  1  holding register full
//  RX_READY      in   1  consumer accepts the byte when RX_VALID & RX_READY
//  RX_FRAME_ERR  out  1  1-cycle pulse: stop bit sampled 0, byte discarded
//  RX_OVERRUN    out  1  1-cycle pulse: new byte dropped because holding register is full
// BEHAVIOUR
//  Reset values:
//   - RX_DATA=0, RX_VALID=0, RX_FRAME_ERR=0, RX_OVERRUN=0.
//   - Synchronizer flops=1, state=IDLE, all counters=0.
//   - RESET mid-frame aborts the frame and discards its partial byte.
//  Input synchronizer: UART_RXD passes through 2 flops to give rxd_s. All decisions use rxd_s.
//  Tick generator:
//   - DIV=(CLK_HZ+BAUD*OS/2)/(BAUD*OS), i.e. CLK_HZ/(BAUD*OS) rounded to nearest.
//   - A free-running counter counts 0..DIV-1. tick is a 1-cycle pulse at DIV-1.
//  Sampling (within a bit, counted by os_cnt 0..OS-1 on ticks):
//   - Sample rxd_s at os_cnt = OS/2-1, OS/2 and OS/2+1.
//   - The bit value is the majority of the 3 samples, decided on the OS/2+1 tick.
//  FSM (advances on tick only, except WAIT_HI):
//   - IDLE: if rxd_s=0, go to START and set os_cnt=0.
//   - START:
//     - At the decision point, if the majority is 1 (glitch), go to IDLE.
//     - At os_cnt=OS-1, go to DATA with bit_cnt=0.
//   - DATA:
//     - Shift the majority bit in, LSB first, at the decision point.
//     - At os_cnt=OS-1, increment bit_cnt. After bit 7, go to STOP.
//   - STOP, at the decision point:
//     - Majority 1: deliver the byte and go to IDLE immediately. The rest of the
//       stop bit is not waited out, so back-to-back frames resynchronise.
//     - Majority 0: pulse RX_FRAME_ERR, discard the byte and go to WAIT_HI.
//   - WAIT_HI: leave for IDLE on any cycle with rxd_s=1. A held break line never
//     starts a new frame.
//  Delivery (registered; RX_VALID rises the cycle after the stop decision tick):
//   - If !RX_VALID, or RX_VALID & RX_READY in the same cycle: load RX_DATA and set RX_VALID=1.
//   - Otherwise keep the old RX_DATA and pulse RX_OVERRUN for 1 cycle.
//   - RX_VALID & RX_READY with no delivery: RX_VALID=0 next cycle. RX_DATA holds its value.
//  Tolerance: a total baud mismatch of at least +/-2% between transmitter and
//  receiver must be received error-free.
// STRUCTURE
//  Shared package uart_pkg:
//   - state enum {IDLE, START, DATA, STOP, WAIT_HI}.
//   - localparam function uart_div(clk_hz, baud, os).
//   - Constant UART_DATA_BITS=8.
//  Sub-module uart_baud_tick (CLOCK_50, RESET -> tick). It is reused by the future uart_tx_8n1.
//  All other logic (synchronizer, FSM, shifter, holding register) lives in this module.
// TESTING  (CLK_HZ=50e6, BAUD=115200, OS=16 -> DIV=27, bit=432 cycles)
//  1. Send 0x55, RX_READY=1 -> RX_VALID pulses 1 cycle with RX_DATA=0x55. No error pulses.
//  2. 100-cycle low glitch on UART_RXD, then idle -> FSM returns to IDLE. No RX_VALID and no errors.
//  3. Send 0xA3 with stop bit 0, line held low 3000 cycles then high -> one RX_FRAME_ERR
//     pulse, no RX_VALID, and no new frame until the line goes high.
//     Then send 0x5A -> 0x5A is received.
//  4. RX_READY=0, send 0x12 then 0x34 -> RX_DATA stays 0x12 and RX_OVERRUN pulses once.
//     Then raise RX_READY -> RX_VALID=0 the next cycle.
//  5. Back-to-back 0x00, 0xFF, 0x81 with no idle gap; bit time 424 and 441 cycles (+/-2%)
//     -> all 3 bytes received in order with no errors.
//  6. Assert RESET during data bit 4 of 0xC3 -> all outputs at reset values next cycle.
//     After release and idle, send 0x3C -> 0x3C is received.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per oversample tick, rounded to nearest.
    function automatic int uart_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator shared by the UART receiver and transmitter.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic CLOCK_50,
    input  logic RESET,
    output logic tick
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OS);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote, one-entry
// valid/ready holding register with framing and overrun error pulses.
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int OS     = 16
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       UART_RXD,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       RX_FRAME_ERR,
    output logic       RX_OVERRUN
);

    localparam int OSW = $clog2(OS);
    localparam int BCW = $clog2(UART_DATA_BITS);
    localparam logic [OSW-1:0] OS_LAST  = OSW'(OS - 1);
    localparam logic [OSW-1:0] SMP_A    = OSW'(OS / 2 - 1);
    localparam logic [OSW-1:0] SMP_B    = OSW'(OS / 2);
    localparam logic [OSW-1:0] SMP_DEC  = OSW'(OS / 2 + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(UART_DATA_BITS - 1);

    logic                      tick;
    logic [1:0]                sync_q, sync_d;
    uart_state_t               state_q, state_d;
    logic [OSW-1:0]            os_cnt_q, os_cnt_d;
    logic [BCW-1:0]            bit_cnt_q, bit_cnt_d;
    logic [1:0]                samp_q, samp_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      ovr_q, ovr_d;
    logic                      rxd_s, maj, decide, deliver;

    uart_baud_tick #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OS(OS)) u_tick (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .tick     (tick)
    );

    assign rxd_s  = sync_q[1];
    assign maj    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);
    assign decide = tick && (os_cnt_q == SMP_DEC);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        sync_d    = {sync_q[0], UART_RXD};
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        // Oversample position and sample capture only run while inside a frame.
        if (tick && (state_q == START || state_q == DATA || state_q == STOP)) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OSW'(1);
            if (os_cnt_q == SMP_A) samp_d[0] = rxd_s;
            if (os_cnt_q == SMP_B) samp_d[1] = rxd_s;
        end
        case (state_q)
            IDLE: begin
                if (tick && !rxd_s) begin
                    state_d  = START;
                    os_cnt_d = '0;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_d = IDLE;
                end else if (tick && os_cnt_q == OS_LAST) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (decide) shift_d = {maj, shift_q[UART_DATA_BITS-1:1]};
                if (tick && os_cnt_q == OS_LAST) begin
                    if (bit_cnt_q == BIT_LAST) state_d = STOP;
                    else                       bit_cnt_d = bit_cnt_q + BCW'(1);
                end
            end
            STOP: begin
                // No wait for the end of the stop bit, so back-to-back frames resync.
                if (decide) state_d = maj ? IDLE : WAIT_HI;
            end
            WAIT_HI: begin
                if (rxd_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        deliver = (state_q == STOP) && decide && maj;
        ferr_d  = (state_q == STOP) && decide && !maj;
        ovr_d   = 1'b0;
        data_d  = data_q;
        valid_d = valid_q;
        if (deliver) begin
            if (!valid_q || RX_READY) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && RX_READY) begin
            valid_d = 1'b0;
        end
    end

    assign RX_DATA      = data_q;
    assign RX_VALID     = valid_q;
    assign RX_FRAME_ERR = ferr_q;
    assign RX_OVERRUN   = ovr_q;

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Directed bench for uart_rx_8n1: drives 8N1 frames and checks delivery and error pulses.
module tb_uart_rx_8n1;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rxd = 1'b1;
    logic       rdy = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ferr, rx_ovr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_bytes [0:31];
    int rx_cnt = 0;
    int v_cyc  = 0;
    int f_cyc  = 0;
    int o_cyc  = 0;

    int v0, f0, o0, r0;

    uart_rx_8n1 #(.CLK_HZ(50000000), .BAUD(115200), .OS(16)) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .UART_RXD     (rxd),
        .RX_DATA      (rx_data),
        .RX_VALID     (rx_valid),
        .RX_READY     (rdy),
        .RX_FRAME_ERR (rx_ferr),
        .RX_OVERRUN   (rx_ovr)
    );

    always #10 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid && rdy) begin
            rx_bytes[rx_cnt[4:0]] <= rx_data;
            rx_cnt <= rx_cnt + 1;
        end
        if (rx_valid) v_cyc <= v_cyc + 1;
        if (rx_ferr)  f_cyc <= f_cyc + 1;
        if (rx_ovr)   o_cyc <= o_cyc + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int bt, input logic stop_bit);
        logic [7:0] v;
        v   = b;
        rxd = 1'b0;
        wait_cyc(bt);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            wait_cyc(bt);
        end
        rxd = stop_bit;
        wait_cyc(bt);
    endtask

    task automatic snap();
        v0 = v_cyc;
        f0 = f_cyc;
        o0 = o_cyc;
        r0 = rx_cnt;
    endtask

    initial begin
        logic [7:0] c3;
        wait_cyc(5);
        chk("reset_data",  32'(rx_data),  32'h0);
        chk("reset_valid", 32'(rx_valid), 32'h0);
        chk("reset_ferr",  32'(rx_ferr),  32'h0);
        chk("reset_ovr",   32'(rx_ovr),   32'h0);
        rst = 1'b0;
        wait_cyc(100);

        // 1: single byte with consumer ready
        snap();
        send_byte(8'h55, 432, 1'b1);
        wait_cyc(600);
        chk("t1_count", 32'(rx_cnt - r0), 32'd1);
        chk("t1_byte",  32'(rx_bytes[r0[4:0]]), 32'h55);
        chk("t1_vcyc",  32'(v_cyc - v0), 32'd1);
        chk("t1_ferr",  32'(f_cyc - f0), 32'd0);
        chk("t1_ovr",   32'(o_cyc - o0), 32'd0);

        // 2: short low glitch is rejected
        snap();
        rxd = 1'b0;
        wait_cyc(100);
        rxd = 1'b1;
        wait_cyc(1000);
        chk("t2_state", 32'(int'(dut.state_q)), 32'(int'(IDLE)));
        chk("t2_vcyc",  32'(v_cyc - v0), 32'd0);
        chk("t2_ferr",  32'(f_cyc - f0), 32'd0);

        // 3: framing error, held break, then recovery
        snap();
        send_byte(8'hA3, 432, 1'b0);
        wait_cyc(3000);
        chk("t3_ferr",     32'(f_cyc - f0), 32'd1);
        chk("t3_vcyc",     32'(v_cyc - v0), 32'd0);
        chk("t3_wait_hi",  32'(int'(dut.state_q)), 32'(int'(WAIT_HI)));
        rxd = 1'b1;
        wait_cyc(500);
        chk("t3_idle",     32'(int'(dut.state_q)), 32'(int'(IDLE)));
        chk("t3_ferr_one", 32'(f_cyc - f0), 32'd1);
        send_byte(8'h5A, 432, 1'b1);
        wait_cyc(600);
        chk("t3_count", 32'(rx_cnt - r0), 32'd1);
        chk("t3_byte",  32'(rx_bytes[r0[4:0]]), 32'h5A);

        // 4: overrun while consumer stalls
        rdy = 1'b0;
        snap();
        send_byte(8'h12, 432, 1'b1);
        wait_cyc(200);
        send_byte(8'h34, 432, 1'b1);
        wait_cyc(600);
        chk("t4_valid", 32'(rx_valid), 32'd1);
        chk("t4_data",  32'(rx_data),  32'h12);
        chk("t4_ovr",   32'(o_cyc - o0), 32'd1);
        chk("t4_ferr",  32'(f_cyc - f0), 32'd0);
        rdy = 1'b1;
        wait_cyc(1);
        chk("t4_drain",  32'(rx_valid), 32'd0);
        chk("t4_hold",   32'(rx_data),  32'h12);
        chk("t4_count",  32'(rx_cnt - r0), 32'd1);
        chk("t4_byte",   32'(rx_bytes[r0[4:0]]), 32'h12);

        // 5: back-to-back frames at -2% and +2% bit time
        snap();
        send_byte(8'h00, 424, 1'b1);
        send_byte(8'hFF, 424, 1'b1);
        send_byte(8'h81, 424, 1'b1);
        wait_cyc(600);
        send_byte(8'h00, 441, 1'b1);
        send_byte(8'hFF, 441, 1'b1);
        send_byte(8'h81, 441, 1'b1);
        wait_cyc(600);
        chk("t5_count", 32'(rx_cnt - r0), 32'd6);
        chk("t5_b0",    32'(rx_bytes[5'(r0 + 0)]), 32'h00);
        chk("t5_b1",    32'(rx_bytes[5'(r0 + 1)]), 32'hFF);
        chk("t5_b2",    32'(rx_bytes[5'(r0 + 2)]), 32'h81);
        chk("t5_b3",    32'(rx_bytes[5'(r0 + 3)]), 32'h00);
        chk("t5_b4",    32'(rx_bytes[5'(r0 + 4)]), 32'hFF);
        chk("t5_b5",    32'(rx_bytes[5'(r0 + 5)]), 32'h81);
        chk("t5_ferr",  32'(f_cyc - f0), 32'd0);
        chk("t5_ovr",   32'(o_cyc - o0), 32'd0);

        // 6: reset during data bit 4, then a clean frame
        c3  = 8'hC3;
        rxd = 1'b0;
        wait_cyc(432);
        for (int i = 0; i < 4; i++) begin
            rxd = c3[i];
            wait_cyc(432);
        end
        rxd = c3[4];
        wait_cyc(200);
        rst = 1'b1;
        rxd = 1'b1;
        wait_cyc(1);
        chk("t6_data",  32'(rx_data),  32'h0);
        chk("t6_valid", 32'(rx_valid), 32'h0);
        chk("t6_ferr",  32'(rx_ferr),  32'h0);
        chk("t6_ovr",   32'(rx_ovr),   32'h0);
        chk("t6_state", 32'(int'(dut.state_q)), 32'(int'(IDLE)));
        rst = 1'b0;
        wait_cyc(1000);
        snap();
        send_byte(8'h3C, 432, 1'b1);
        wait_cyc(600);
        chk("t6_count", 32'(rx_cnt - r0), 32'd1);
        chk("t6_byte",  32'(rx_bytes[r0[4:0]]), 32'h3C);
        chk("t6_err",   32'((f_cyc - f0) + (o_cyc - o0)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
